multiplier_pipe: RTL and testbench
==================================

MULTIPLIER_PIPE -- requirements
Module: multiplier_pipe

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter STAGES, default 3, giving the pipeline depth in cycles; legal values are 1 to 8.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port iRstN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iClr, input, 1 bit: synchronous flush.
REQ-006 The block SHALL have port iValid, input, 1 bit: an operand beat is present.
REQ-007 The block SHALL have port oReady, output, 1 bit: the block can accept a beat.
REQ-008 The block SHALL have port iData0, input, BITWIDTH bits: the multiplicand.
REQ-009 The block SHALL have port iData1, input, BITWIDTH bits: the multiplier.
REQ-010 The block SHALL have port iSigned, input, 1 bit: when 1, the beat uses two's-complement operands.
REQ-011 The block SHALL have port oValid, output, 1 bit: oData holds a result.
REQ-012 The block SHALL have port iReady, input, 1 bit: the downstream consumer accepts the result.
REQ-013 The block SHALL have port oData, output, 2*BITWIDTH bits: the result.
REQ-014 The block SHALL have port iAcc, input, 1 bit, present only when the configuration macro is defined: accumulate flag for the beat.

Function
REQ-015 A beat SHALL be accepted on a rising edge where iValid=1 and oReady=1; a result SHALL be consumed on a rising edge where oValid=1 and iReady=1.
REQ-016 oReady SHALL equal (!oValid || iReady) combinationally; the pipeline SHALL advance only when oReady=1 and SHALL hold all stages otherwise.
REQ-017 An accepted beat SHALL appear on oData with oValid=1 exactly STAGES cycles after acceptance when no stall occurs; each stall cycle SHALL add one cycle of latency.
REQ-018 The block SHALL sustain one beat per cycle while iReady=1 permanently.
REQ-019 When iSigned=0, the result SHALL be the exact unsigned product; when iSigned=1, it SHALL be the exact 2*BITWIDTH-bit signed product.
REQ-020 iSigned and iAcc SHALL be captured per beat and SHALL travel through the pipeline with their beat.
REQ-021 Empty bubbles SHALL propagate with valid=0 and SHALL NOT alter oData.
REQ-022 oData and oValid SHALL hold stable while oValid=1 and iReady=0.
REQ-023 After consumption, oData SHALL retain the last result; oValid SHALL drop to 0 unless a new result arrives on the same edge.
REQ-024 iClr=1 SHALL clear every stage valid bit, oValid, oData, and all pipeline data to 0 on the next edge; it SHALL override any accept or consume in that cycle, and a beat presented in that cycle SHALL be discarded.
REQ-025 oReady SHALL remain (!oValid || iReady) during iClr; the discarding is governed by REQ-024.

Reset
REQ-026 iRstN=0 SHALL immediately, without a clock, force oValid=0, oData=0, all stage valid bits to 0, and all pipeline registers to 0.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight beats; the first beat accepted after release SHALL produce a result after STAGES cycles.
REQ-028 After reset, oReady SHALL be 1.

Configuration
REQ-029 When macro MULTIPLIER_PIPE_ACC_EN is defined, iAcc SHALL exist; a beat with iAcc=1 SHALL produce the current oData register value plus its product, modulo 2^(2*BITWIDTH); a beat with iAcc=0 SHALL produce the bare product.
REQ-030 Accumulation SHALL use the oData register value at the edge the beat reaches the output stage; back-to-back accumulating beats SHALL chain correctly.
REQ-031 iClr and reset SHALL zero the accumulated value.
REQ-032 When MULTIPLIER_PIPE_ACC_EN is undefined, iAcc SHALL NOT exist and every result SHALL be the bare product.

Verification
REQ-033 The bench SHALL check, with BITWIDTH=8, STAGES=3, iReady=1: beats 0xFF*0xFF with iSigned=0 then iSigned=1 -> oData=0xFE01 at cycle +3, then 0x0001 at cycle +4.
REQ-034 The bench SHALL check a signed beat 0x80*0x80 -> 0x4000, and a signed beat 0x80*0x01 -> 0xFF80.
REQ-035 The bench SHALL check a stream of 10 beats with iReady toggling 1,0,0,1,...: no beat is lost or duplicated, oData is stable while stalled, and oReady=0 exactly when oValid=1 and iReady=0.
REQ-036 The bench SHALL check iClr asserted with 3 beats in flight: oValid=0 and oData=0 on the next edge, no stale results afterwards, and a new beat's result after 3 cycles.
REQ-037 The bench SHALL check iRstN pulsed low mid-stream between clock edges: outputs zero immediately and oReady=1.
REQ-038 The bench SHALL check, with MULTIPLIER_PIPE_ACC_EN defined: beats 3*4 (iAcc=0), 5*6 (iAcc=1), 0xFF*0xFF (iAcc=1) -> oData 0x000C, 0x002A, 0xFE2B.

Source files
------------

// File: rtl/multiplier_pipe.sv
// -----------------------------------------------------------------------------
// multiplier_pipe
//
// Pipelined signed/unsigned multiplier with valid/ready handshake on both the
// operand side and the result side. The product is formed combinationally as
// the beat is accepted and is then carried through STAGES registers. The last
// register is the output register (oData). The whole pipeline moves as one
// unit: it advances when oReady=1 and holds every stage otherwise.
//
// Optional feature: define MULTIPLIER_PIPE_ACC_EN to add the iAcc port. A beat
// with iAcc=1 adds its product to the value already in the output register at
// the moment the beat lands there, so back-to-back accumulating beats chain.
//
// Parameters
//   BITWIDTH : operand width in bits (result is 2*BITWIDTH bits)
//   STAGES   : pipeline depth in cycles, 1..8
//
// Ports
//   iClk    : clock, rising edge
//   iRstN   : asynchronous active-low reset, clears all state
//   iClr    : synchronous flush, clears all state, overrides accept/consume
//   iValid  : operand beat present          oReady : beat can be accepted
//   iData0  : multiplicand                  iData1 : multiplier
//   iSigned : two's-complement operands for this beat
//   iAcc    : accumulate flag for this beat (MULTIPLIER_PIPE_ACC_EN only)
//   oValid  : oData holds a result          iReady : consumer takes the result
//   oData   : result, 2*BITWIDTH bits
// -----------------------------------------------------------------------------
module multiplier_pipe #(
  parameter int BITWIDTH = 32,
  parameter int STAGES   = 3
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iClr,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [BITWIDTH-1:0]     iData0,
  input  logic [BITWIDTH-1:0]     iData1,
  input  logic                    iSigned,
`ifdef MULTIPLIER_PIPE_ACC_EN
  input  logic                    iAcc,
`endif
  output logic                    oValid,
  input  logic                    iReady,
  output logic [2*BITWIDTH-1:0]   oData
);

  localparam int PW   = 2 * BITWIDTH;
  localparam int LAST = STAGES - 1;

  // Operand extension and product for the beat at the input.
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod_in;
  logic          acc_in;

  // Per-stage state; index LAST is the output register.
  logic          vld_reg  [STAGES];
  logic [PW-1:0] prod_reg [STAGES];
  logic          acc_reg  [STAGES];

  // What each stage would load on an advancing edge.
  logic          sin_vld  [STAGES];
  logic [PW-1:0] sin_prod [STAGES];
  logic          sin_acc  [STAGES];

  logic          advance;

  // Extending both operands to the full result width and keeping only the low
  // PW bits of the product gives the exact signed product for signed beats
  // and the exact unsigned product for unsigned beats.
  always_comb begin
    a_ext   = '0;
    b_ext   = '0;
    prod_in = '0;
    if (iSigned) begin
      a_ext = {{BITWIDTH{iData0[BITWIDTH-1]}}, iData0};
      b_ext = {{BITWIDTH{iData1[BITWIDTH-1]}}, iData1};
    end else begin
      a_ext = {{BITWIDTH{1'b0}}, iData0};
      b_ext = {{BITWIDTH{1'b0}}, iData1};
    end
    prod_in = a_ext * b_ext;
  end

`ifdef MULTIPLIER_PIPE_ACC_EN
  assign acc_in = iAcc;
`else
  assign acc_in = 1'b0;
`endif

  // Stage 0 is fed from the ports, every later stage from its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_in
      if (gi == 0) begin : g_first
        assign sin_vld[gi]  = iValid;
        assign sin_prod[gi] = prod_in;
        assign sin_acc[gi]  = acc_in;
      end else begin : g_next
        assign sin_vld[gi]  = vld_reg[gi-1];
        assign sin_prod[gi] = prod_reg[gi-1];
        assign sin_acc[gi]  = acc_reg[gi-1];
      end
    end
  endgenerate

  assign oValid  = vld_reg[LAST];
  assign oData   = prod_reg[LAST];
  assign oReady  = !oValid || iReady;
  assign advance = oReady;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_reg[s]  <= 1'b0;
        prod_reg[s] <= '0;
        acc_reg[s]  <= 1'b0;
      end
    end else if (iClr) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_reg[s]  <= 1'b0;
        prod_reg[s] <= '0;
        acc_reg[s]  <= 1'b0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_reg[s] <= sin_vld[s];
        // Bubbles leave data untouched so oData keeps the last result.
        if (sin_vld[s]) begin
          acc_reg[s] <= sin_acc[s];
          if (s == LAST && sin_acc[s]) begin
            // Accumulate onto the current output register contents.
            prod_reg[s] <= prod_reg[s] + sin_prod[s];
          end else begin
            prod_reg[s] <= sin_prod[s];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_pipe.sv
// -----------------------------------------------------------------------------
// tb_multiplier_pipe
//
// Self-checking bench for multiplier_pipe with BITWIDTH=8, STAGES=3. A
// reference model tracks each accepted beat as a queue entry with an age in
// pipeline advances; once a beat has been carried STAGES times it becomes the
// expected output. Products come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_multiplier_pipe;

  localparam int W  = 8;
  localparam int ST = 3;
`ifdef MULTIPLIER_PIPE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iClr;
  logic          iValid;
  logic          oReady;
  logic [W-1:0]  iData0;
  logic [W-1:0]  iData1;
  logic          iSigned;
  logic          iAcc;
  logic          oValid;
  logic          iReady;
  logic [2*W-1:0] oData;

  always #5 iClk = ~iClk;

  multiplier_pipe #(.BITWIDTH(W), .STAGES(ST)) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iClr    (iClr),
    .iValid  (iValid),
    .oReady  (oReady),
    .iData0  (iData0),
    .iData1  (iData1),
    .iSigned (iSigned),
`ifdef MULTIPLIER_PIPE_ACC_EN
    .iAcc    (iAcc),
`endif
    .oValid  (oValid),
    .iReady  (iReady),
    .oData   (oData)
  );

  typedef struct {
    logic [2*W-1:0] val;
    bit             acc;
    int             age;
  } beat_t;

  beat_t          model_q[$];
  bit             exp_valid;
  logic [2*W-1:0] exp_data;
  int             n_checks;
  int             n_fail;
  int             n_consumed;
  bit             last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input int a, input int b, input bit s);
    int x;
    int y;
    x = a;
    y = b;
    if (s) begin
      if (x >= (1 << (W-1))) x = x - (1 << W);
      if (y >= (1 << (W-1))) y = y - (1 << W);
    end
    return (2*W)'(x * y);
  endfunction

  task automatic model_reset();
    model_q.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input bit acc);
    iValid  = v;
    iData0  = a;
    iData1  = b;
    iSigned = s;
    iAcc    = acc;
  endtask

  // One clock cycle: called just after an active edge with inputs driven.
  task automatic cycle();
    bit             pre_v;
    logic [2*W-1:0] pre_d;
    bit             rdy;
    bit             clr;
    bit             adv;
    bit             acc_now;
    beat_t          nb;
    beat_t          ob;
    #1;
    check("oready", oReady, 32'(!exp_valid || iReady));
    pre_v   = oValid;
    pre_d   = oData;
    rdy     = iReady;
    clr     = iClr;
    adv     = !exp_valid || rdy;
    acc_now = iValid && adv && !clr;
    nb.val  = ref_mul(int'(iData0), int'(iData1), iSigned);
    nb.acc  = ACC_EN && iAcc;
    nb.age  = 1;
    if (exp_valid && rdy && !clr) begin
      n_consumed++;
      $display("t=%0t result consumed data=%h", $time, pre_d);
    end
    @(posedge iClk);
    #1;
    last_accept = acc_now;
    if (clr) begin
      model_reset();
    end else if (adv) begin
      foreach (model_q[i]) model_q[i].age++;
      if (acc_now) model_q.push_back(nb);
      if (model_q.size() > 0 && model_q[0].age == ST) begin
        ob        = model_q.pop_front();
        exp_data  = ob.acc ? exp_data + ob.val : ob.val;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    check("ovalid", oValid, 32'(exp_valid));
    check("odata", oData, 32'(exp_data));
    if (pre_v && !rdy && !clr) check("stall_hold", oData, 32'(pre_d));
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_consumed = 0;
    iRstN  = 1'b0;
    iClr   = 1'b0;
    iReady = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    check("reset_ovalid", oValid, 0);
    check("reset_odata", oData, 0);
    check("reset_oready", oReady, 1);
    iRstN = 1'b1;

    // 0xFF*0xFF unsigned then signed, back to back.
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);       cycle();
    check("ff_unsigned", oData, 32'h0000_FE01);
    check("ff_unsigned_v", oValid, 1);
    cycle();
    check("ff_signed", oData, 32'h0000_0001);
    idle(3);

    // Signed corner operands.
    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0); cycle();
    drive(1'b1, 8'h80, 8'h01, 1'b1, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);       cycle();
    check("s80x80", oData, 32'h0000_4000);
    cycle();
    check("s80x01", oData, 32'h0000_FF80);
    idle(3);

    // Stream of 10 beats with iReady pattern 1,0,0 repeating.
    begin
      int  sent;
      bit  need_new;
      n_consumed = 0;
      sent       = 0;
      need_new   = 1'b1;
      for (int c = 0; c < 200 && !(sent == 10 && n_consumed == 10); c++) begin
        iReady = (c % 3 == 0);
        if (sent < 10) begin
          if (need_new) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
          need_new = 1'b0;
        end else begin
          iValid = 1'b0;
        end
        cycle();
        if (last_accept) begin
          sent++;
          need_new = 1'b1;
        end
      end
      check("stream_consumed", n_consumed, 10);
      check("stream_sent", sent, 10);
    end
    iReady = 1'b1;
    idle(4);

    // Flush with three beats in flight; the beat offered with iClr is dropped.
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h55, 8'h66, 1'b1, 1'b0); cycle();
    iClr = 1'b1;
    drive(1'b1, 8'h77, 8'h88, 1'b0, 1'b0); cycle();
    iClr = 1'b0;
    check("clr_ovalid", oValid, 0);
    check("clr_odata", oData, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("clr_no_stale", oValid, 0);
    end
    drive(1'b1, 8'h07, 8'h03, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);       cycle();
    cycle();
    check("clr_after_v", oValid, 1);
    check("clr_after_d", oData, 32'h0000_0015);
    idle(2);

    // Asynchronous reset between edges with beats in flight.
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h56, 8'h78, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);       cycle();
    #2;
    iRstN = 1'b0;
    #1;
    check("arst_ovalid", oValid, 0);
    check("arst_odata", oData, 0);
    check("arst_oready", oReady, 1);
    model_reset();
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    drive(1'b1, 8'h10, 8'h10, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);       cycle();
    check("arst_early", oValid, 0);
    cycle();
    check("arst_after_d", oData, 32'h0000_0100);
    idle(2);

`ifdef MULTIPLIER_PIPE_ACC_EN
    // Chained accumulation.
    drive(1'b1, 8'h03, 8'h04, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h05, 8'h06, 1'b0, 1'b1); cycle();
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("acc_1", oData, 32'h0000_000C);
    cycle();
    check("acc_2", oData, 32'h0000_002A);
    cycle();
    check("acc_3", oData, 32'h0000_FE2B);
    idle(2);
`endif

    // Full-rate random stream.
    iReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      check("full_rate_accept", 32'(last_accept), 1);
    end
    idle(5);
    check("drained", model_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
